// File: rtl/jtag_pkg.sv
// Shared definitions for the virtual-JTAG scan blocks.
//  - IR status bit positions reported back to the hub through ir_out.
//  - chan_idx_t: instruction / channel-select code at the default IR width.
//  - is_bypass(): an IR code selects bypass when it names no data channel.
package jtag_pkg;

    localparam int JTAG_IR_WIDTH = 2;

    // Bit positions inside ir_out
    localparam int IR_STAT_ERR  = 0;
    localparam int IR_STAT_CHAN = 1;

    typedef logic [JTAG_IR_WIDTH-1:0] chan_idx_t;

    function automatic logic is_bypass(input int unsigned code, input int unsigned num_channels);
        return (code >= num_channels);
    endfunction

endpackage

// File: rtl/jtag_shift_counter.sv
// Saturating shift-length counter for scan chains.
// Ports:
//  clk    in   clock (tck)
//  reset  in   synchronous active-high reset, clears the count
//  clear  in   zero the count (wins over inc)
//  inc    in   count one shift; holds once SAT_VALUE is reached
//  count  out  current count
module jtag_shift_counter
    import jtag_pkg::*;
#(
    parameter int unsigned      WIDTH     = 6,
    parameter logic [WIDTH-1:0] SAT_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count_reg != SAT_VALUE)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/jtag_scan_bank.sv
// Multi-channel data-register bank for a virtual JTAG hub. The hub instance
// (sld_virtual_jtag) lives one level up and drives clk from its tck; this
// block holds only the data-register side.
// The IR selects one of NUM_CHANNELS DATA_WIDTH-bit scan registers, or a
// 1-bit bypass for any code >= NUM_CHANNELS. A DR scan is only committed on
// update when exactly DATA_WIDTH bits were shifted; anything else sets a
// sticky error reported in ir_out and cleared by the next IR update.
// Ports:
//  clk, reset            tck and synchronous active-high reset
//  ir_in / ir_out        instruction from hub / status {.., chan_selected, err}
//  tdi / tdo             serial data, LSB first
//  state_cdr/sdr/udr/uir virtual JTAG state qualifiers
//  cap_data              capture words, channel 0 in the LSBs
//  cap_strobe            one-cycle pulse per captured channel
//  update_data           last accepted update word (shared by all channels)
//  update_valid          one-cycle pulse naming the channel update_data is for
module jtag_scan_bank
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH     = JTAG_IR_WIDTH,
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [IR_WIDTH-1:0]                ir_in,
    output logic [IR_WIDTH-1:0]                ir_out,
    input  logic                               tdi,
    output logic                               tdo,
    input  logic                               state_cdr,
    input  logic                               state_sdr,
    input  logic                               state_udr,
    input  logic                               state_uir,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] cap_data,
    output logic [NUM_CHANNELS-1:0]            cap_strobe,
    output logic [DATA_WIDTH-1:0]              update_data,
    output logic [NUM_CHANNELS-1:0]            update_valid
);

    // Counter saturates one past a full word so long scans stay distinguishable.
    localparam int unsigned      CNT_WIDTH = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT  = CNT_WIDTH'(DATA_WIDTH + 1);

    logic [IR_WIDTH-1:0]     sel_reg, sel_next;
    logic [DATA_WIDTH-1:0]   sr_reg, sr_next;
    logic                    byp_reg, byp_next;
    logic                    err_reg, err_next;
    logic [IR_WIDTH-1:0]     ir_out_reg, ir_out_next;
    logic [NUM_CHANNELS-1:0] cap_strobe_reg, cap_strobe_next;
    logic [DATA_WIDTH-1:0]   update_data_reg, update_data_next;
    logic [NUM_CHANNELS-1:0] update_valid_reg, update_valid_next;

    logic                    cnt_clear;
    logic                    cnt_inc;
    logic [CNT_WIDTH-1:0]    cnt;

    logic [NUM_CHANNELS-1:0] sel_onehot;
    logic [DATA_WIDTH-1:0]   cap_words [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   cap_word;
    logic                    sel_is_chan;

    jtag_shift_counter #(
        .WIDTH     (CNT_WIDTH),
        .SAT_VALUE (CNT_SAT)
    ) u_shift_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (cnt)
    );

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign sel_onehot[gi] = (sel_reg == IR_WIDTH'(gi));
            assign cap_words[gi]  = cap_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign sel_is_chan = !is_bypass(32'(sel_reg), NUM_CHANNELS);

    always_comb begin
        cap_word = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (sel_onehot[i]) begin
                cap_word = cap_words[i];
            end
        end
    end

    always_comb begin
        sel_next          = sel_reg;
        sr_next           = sr_reg;
        byp_next          = byp_reg;
        err_next          = err_reg;
        update_data_next  = update_data_reg;
        cap_strobe_next   = '0;
        update_valid_next = '0;
        cnt_clear         = 1'b0;
        cnt_inc           = 1'b0;

        if (state_cdr) begin
            cnt_clear = 1'b1;
            if (sel_is_chan) begin
                sr_next = cap_word;
                // A capture state held over two cycles must not stretch the strobe.
                if (cap_strobe_reg == '0) begin
                    cap_strobe_next = sel_onehot;
                end
            end else begin
                byp_next = 1'b0;
            end
        end else if (state_sdr) begin
            cnt_inc = 1'b1;
            if (sel_is_chan) begin
                sr_next = {tdi, sr_reg[DATA_WIDTH-1:1]};
            end else begin
                byp_next = tdi;
            end
        end else if (state_udr) begin
            if (sel_is_chan) begin
                if (cnt == CNT_FULL) begin
                    if (update_valid_reg == '0) begin
                        update_data_next  = sr_reg;
                        update_valid_next = sel_onehot;
                    end
                end else begin
                    err_next = 1'b1;
                end
            end
        end else if (state_uir) begin
            sel_next = ir_in;
            err_next = 1'b0;
        end

        // Status follows the registers with no extra latency, but reads 0 in reset.
        ir_out_next               = '0;
        ir_out_next[IR_STAT_ERR]  = err_next;
        ir_out_next[IR_STAT_CHAN] = !is_bypass(32'(sel_next), NUM_CHANNELS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_reg          <= '0;
            sr_reg           <= '0;
            byp_reg          <= 1'b0;
            err_reg          <= 1'b0;
            ir_out_reg       <= '0;
            cap_strobe_reg   <= '0;
            update_data_reg  <= '0;
            update_valid_reg <= '0;
        end else begin
            sel_reg          <= sel_next;
            sr_reg           <= sr_next;
            byp_reg          <= byp_next;
            err_reg          <= err_next;
            ir_out_reg       <= ir_out_next;
            cap_strobe_reg   <= cap_strobe_next;
            update_data_reg  <= update_data_next;
            update_valid_reg <= update_valid_next;
        end
    end

    assign tdo          = sel_is_chan ? sr_reg[0] : byp_reg;
    assign ir_out       = ir_out_reg;
    assign cap_strobe   = cap_strobe_reg;
    assign update_data  = update_data_reg;
    assign update_valid = update_valid_reg;

endmodule

// File: tb/tb_jtag_scan_bank.sv
// Bench for jtag_scan_bank: expectations are queued as each step is driven
// and popped against the DUT outputs once the step has been clocked.
module tb_jtag_scan_bank;
    import jtag_pkg::*;

    localparam int IRW = 2;
    localparam int NCH = 3;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [IRW-1:0]    ir_in;
    logic [IRW-1:0]    ir_out;
    logic              tdi;
    logic              tdo;
    logic              state_cdr, state_sdr, state_udr, state_uir;
    logic [NCH*DW-1:0] cap_data;
    logic [NCH-1:0]    cap_strobe;
    logic [DW-1:0]     update_data;
    logic [NCH-1:0]    update_valid;

    int vectors     = 0;
    int miscompares = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    jtag_scan_bank #(
        .IR_WIDTH     (IRW),
        .NUM_CHANNELS (NCH),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ir_in        (ir_in),
        .ir_out       (ir_out),
        .tdi          (tdi),
        .tdo          (tdo),
        .state_cdr    (state_cdr),
        .state_sdr    (state_sdr),
        .state_udr    (state_udr),
        .state_uir    (state_uir),
        .cap_data     (cap_data),
        .cap_strobe   (cap_strobe),
        .update_data  (update_data),
        .update_valid (update_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_eq(t, obs, e);
        end
    endtask

    task automatic push_outputs(input string p, input logic [31:0] ir, input logic [31:0] cs,
                                input logic [31:0] ud, input logic [31:0] uv, input logic [31:0] td);
        sb_push({p, "_ir_out"}, ir);
        sb_push({p, "_cap_strobe"}, cs);
        sb_push({p, "_update_data"}, ud);
        sb_push({p, "_update_valid"}, uv);
        sb_push({p, "_tdo"}, td);
    endtask

    task automatic pop_outputs();
        sb_pop(32'(ir_out));
        sb_pop(32'(cap_strobe));
        sb_pop(update_data);
        sb_pop(32'(update_valid));
        sb_pop(32'(tdo));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_uir(input chan_idx_t code);
        ir_in     = code;
        state_uir = 1'b1;
        tick();
        state_uir = 1'b0;
        $display("[%0t] uir ir_in=%0d", $time, code);
    endtask

    task automatic do_cdr();
        state_cdr = 1'b1;
        tick();
        state_cdr = 1'b0;
        $display("[%0t] cdr", $time);
    endtask

    task automatic do_udr();
        state_udr = 1'b1;
        tick();
        state_udr = 1'b0;
        $display("[%0t] udr", $time);
    endtask

    // tdo is sampled before each shift edge, so dout[i] is the i-th bit out.
    task automatic scan(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            tdi       = din[i];
            state_sdr = 1'b1;
            dout[i]   = tdo;
            tick();
        end
        state_sdr = 1'b0;
        tdi       = 1'b0;
        $display("[%0t] sdr x%0d in=%h out=%h", $time, n, din, dout);
    endtask

    initial begin
        logic [63:0] d;

        reset     = 1'b1;
        ir_in     = '0;
        tdi       = 1'b0;
        state_cdr = 1'b0;
        state_sdr = 1'b0;
        state_udr = 1'b0;
        state_uir = 1'b0;
        cap_data  = {32'hA5C3_0F96, 32'hDEAD_BEEF, 32'h0BAD_F00D};

        tick();
        tick();
        push_outputs("rst", 0, 0, 0, 0, 0);
        pop_outputs();
        reset = 1'b0;
        tick();
        sb_push("rst_release_ir_out", 32'h2);
        sb_pop(32'(ir_out));

        // 1: capture channel 1 and shift it out LSB first
        do_uir(2'd1);
        sb_push("t1_ir_out", 32'h2);
        sb_pop(32'(ir_out));
        do_cdr();
        sb_push("t1_cap_strobe", 32'h2);
        sb_push("t1_tdo_first", 32'h1);
        sb_pop(32'(cap_strobe));
        sb_pop(32'(tdo));
        sb_push("t1_byte0", 32'hEF);
        sb_push("t1_byte1", 32'hBE);
        sb_push("t1_byte2", 32'hAD);
        sb_push("t1_byte3", 32'hDE);
        sb_push("t1_cap_strobe_once", 32'h0);
        scan(32, 64'h0, d);
        sb_pop(32'(d[7:0]));
        sb_pop(32'(d[15:8]));
        sb_pop(32'(d[23:16]));
        sb_pop(32'(d[31:24]));
        sb_pop(32'(cap_strobe));

        // 2: full-length scan into channel 2 and update
        do_uir(2'd2);
        do_cdr();
        sb_push("t2_cap_strobe", 32'h4);
        sb_pop(32'(cap_strobe));
        sb_push("t2_tdo_word", 32'hA5C3_0F96);
        scan(32, 64'h1234_5678, d);
        sb_pop(d[31:0]);
        sb_push("t2_update_data", 32'h1234_5678);
        sb_push("t2_update_valid", 32'h4);
        do_udr();
        sb_pop(update_data);
        sb_pop(32'(update_valid));
        tick();
        sb_push("t2_update_valid_drop", 32'h0);
        sb_push("t2_ir_out", 32'h2);
        sb_pop(32'(update_valid));
        sb_pop(32'(ir_out));

        // 3: short scan on channel 0 sets the sticky error; uir clears it
        do_uir(2'd0);
        do_cdr();
        sb_push("t3_cap_strobe", 32'h1);
        sb_pop(32'(cap_strobe));
        scan(31, 64'h0F0F_AAAA, d);
        do_udr();
        sb_push("t3_update_valid", 32'h0);
        sb_push("t3_update_data", 32'h1234_5678);
        sb_push("t3_ir_out_err", 32'h3);
        sb_pop(32'(update_valid));
        sb_pop(update_data);
        sb_pop(32'(ir_out));
        do_uir(2'd0);
        sb_push("t3_ir_out_clear", 32'h2);
        sb_pop(32'(ir_out));

        // 4: long scan also sets the error and leaves update_data alone
        do_cdr();
        sb_push("t4_tdo_word", 32'h0BAD_F00D);
        scan(33, 64'h1_FFFF_0000, d);
        sb_pop(d[31:0]);
        do_udr();
        sb_push("t4_update_valid", 32'h0);
        sb_push("t4_update_data", 32'h1234_5678);
        sb_push("t4_ir_out_err", 32'h3);
        sb_pop(32'(update_valid));
        sb_pop(update_data);
        sb_pop(32'(ir_out));

        // 5: bypass delays tdi by one shift
        do_uir(2'd3);
        sb_push("t5_ir_out", 32'h0);
        sb_pop(32'(ir_out));
        do_cdr();
        sb_push("t5_cap_strobe", 32'h0);
        sb_pop(32'(cap_strobe));
        sb_push("t5_tdo_seq", 32'h2);
        scan(3, 64'h5, d);
        sb_pop(32'(d[2:0]));
        sb_push("t5_tdo_last", 32'h1);
        sb_pop(32'(tdo));
        do_udr();
        sb_push("t5_update_valid", 32'h0);
        sb_push("t5_update_data", 32'h1234_5678);
        sb_push("t5_ir_out_after_udr", 32'h0);
        sb_pop(32'(update_valid));
        sb_pop(update_data);
        sb_pop(32'(ir_out));

        // 6: reset mid-scan discards the scan
        do_uir(2'd0);
        do_cdr();
        scan(16, 64'hFFFF, d);
        reset     = 1'b1;
        state_udr = 1'b1;
        tick();
        state_udr = 1'b0;
        $display("[%0t] reset with udr", $time);
        push_outputs("t6_rst", 0, 0, 0, 0, 0);
        pop_outputs();
        reset = 1'b0;
        do_udr();
        sb_push("t6_update_valid", 32'h0);
        sb_push("t6_update_data", 32'h0);
        sb_push("t6_ir_out_err", 32'h3);
        sb_pop(32'(update_valid));
        sb_pop(update_data);
        sb_pop(32'(ir_out));

        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
